// File: rtl/core_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// core_ctrl_pkg
// Shared definitions for the attention-core sequencer:
//   - state_e   : sequencer states, in pass order
//   - INST_*    : bit positions / field widths of the 20-bit core inst word
//   - max_int   : elaboration-time helper for sizing counters
// ---------------------------------------------------------------------------
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_QWR   = 4'd1,
    ST_KWR   = 4'd2,
    ST_KLOAD = 4'd3,
    ST_EXEC  = 4'd4,
    ST_DRAIN = 4'd5,
    ST_PWR   = 4'd6,
    ST_NRD   = 4'd7,
    ST_NWAIT = 4'd8,
    ST_NWB   = 4'd9,
    ST_DONE  = 4'd10
  } state_e;

  localparam int INST_W          = 20;
  localparam int INST_ADDR_W     = 4;   // width of the qk and psum address fields
  localparam int INST_SFP_RD     = 19;
  localparam int INST_NORM_VALID = 18;
  localparam int INST_NORM_START = 17;
  localparam int INST_OFIFO_RD   = 16;
  localparam int INST_QK_LSB     = 12;  // qk addr occupies [15:12]
  localparam int INST_PSUM_LSB   = 8;   // psum addr occupies [11:8]
  localparam int INST_EXEC       = 7;
  localparam int INST_KLOAD      = 6;
  localparam int INST_QMEM_RD    = 5;
  localparam int INST_QMEM_WR    = 4;
  localparam int INST_KMEM_RD    = 3;
  localparam int INST_KMEM_WR    = 2;
  localparam int INST_PMEM_RD    = 1;
  localparam int INST_PMEM_WR    = 0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/core_seq_ctrl_phase_cnt.sv
// ---------------------------------------------------------------------------
// phase_cnt
// Up-counter shared by every timed / counted sequencer state.
// Ports:
//   clk, reset    clock, async active-high reset
//   load_i        load load_val_i (has priority over en_i)
//   load_val_i    value loaded on load_i
//   en_i          increment enable
//   term_i        terminal value to compare against
//   cnt_o         current count
//   tc_o          cnt_o == term_i
// ---------------------------------------------------------------------------
module phase_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/core_seq_ctrl.sv
// ---------------------------------------------------------------------------
// core_seq_ctrl
// Pass sequencer for the attention core. Walks Q load, K load, K preload,
// execute, ofifo->psum write, norm read and norm write-back, emitting the
// registered 20-bit core inst word. The inst word is decoded from the
// current state/count and registered, so it trails the state by one cycle.
// Ports:
//   clk, reset     clock, async active-high reset
//   start          pulse, begins a pass when idle (clears err)
//   abort          return to IDLE next cycle, inst forced to 0
//   in_valid       host word valid (counted only while in_ready)
//   in_ready       high during Q/K load states
//   ofifo_valid    ends DRAIN
//   div_complete   ends NWAIT
//   inst           core instruction word
//   busy           state != IDLE
//   done           one-cycle pulse at end of a completed pass
//   err            sticky watchdog timeout flag
// ---------------------------------------------------------------------------
module core_seq_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int col    = 8,
  parameter int len    = 8,
  parameter int addr_w = 4,
  parameter int wd_max = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ofifo_valid,
  input  logic              div_complete,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Phase counter must reach max(col,len) (the extra read-latency cycle).
  localparam int PW  = $clog2(max_int(col, len) + 2);
  localparam int WDW = $clog2(wd_max + 1);

  localparam logic [PW-1:0]  COL_C    = PW'(col);
  localparam logic [PW-1:0]  LEN_C    = PW'(len);
  localparam logic [PW-1:0]  COL_LAST = PW'(col - 1);
  localparam logic [PW-1:0]  LEN_LAST = PW'(len - 1);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(wd_max - 1);

  state_e             state_q, state_d;
  logic [WDW-1:0]     wd_q, wd_d;
  logic               err_q, err_d;
  logic [INST_W-1:0]  inst_q, inst_d;
  logic               busy_q, done_q, ready_q;
  logic               timeout;

  logic               ph_load, ph_en, ph_tc;
  logic [PW-1:0]      ph_term, ph_cnt;

  logic [addr_w-1:0]      cur_addr, prev_addr;
  logic [INST_ADDR_W-1:0] cur_field, prev_field;
  logic                   not_first, below_len, below_col;

  phase_cnt #(.W(PW)) u_phase (
    .clk        (clk),
    .reset      (reset),
    .load_i     (ph_load),
    .load_val_i ({PW{1'b0}}),
    .en_i       (ph_en),
    .term_i     (ph_term),
    .cnt_o      (ph_cnt),
    .tc_o       (ph_tc)
  );

  // Load states count accepted words; timed states count every cycle.
  always_comb begin
    ph_term = '0;
    ph_en   = 1'b0;
    case (state_q)
      ST_QWR:   begin ph_term = LEN_LAST; ph_en = in_valid; end
      ST_KWR:   begin ph_term = COL_LAST; ph_en = in_valid; end
      ST_KLOAD: begin ph_term = COL_C;    ph_en = 1'b1;     end
      ST_EXEC, ST_PWR, ST_NRD, ST_NWB: begin
        ph_term = LEN_C;
        ph_en   = 1'b1;
      end
      default: ;
    endcase
  end

  // Every state change restarts the phase count from zero.
  assign ph_load = (state_d != state_q);

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    err_d   = err_q;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) begin state_d = ST_QWR; err_d = 1'b0; end
      ST_QWR:   if (in_valid && ph_tc) state_d = ST_KWR;
      ST_KWR:   if (in_valid && ph_tc) state_d = ST_KLOAD;
      ST_KLOAD: if (ph_tc) state_d = ST_EXEC;
      ST_EXEC:  if (ph_tc) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (ofifo_valid)          state_d = ST_PWR;
        else if (wd_q == WD_LAST) timeout = 1'b1;
        else                      wd_d = wd_q + 1'b1;
      end
      ST_PWR:   if (ph_tc) state_d = ST_NRD;
      ST_NRD:   if (ph_tc) state_d = ST_NWAIT;
      ST_NWAIT: begin
        if (div_complete)         state_d = ST_NWB;
        else if (wd_q == WD_LAST) timeout = 1'b1;
        else                      wd_d = wd_q + 1'b1;
      end
      ST_NWB:   if (ph_tc) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (timeout) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end

    // abort overrides everything, including a start or a timeout this cycle.
    if (abort) begin
      state_d = ST_IDLE;
      err_d   = err_q;
    end

    // Watchdog restarts on entry to either wait state.
    if (state_d != state_q) begin
      wd_d = '0;
    end
  end

  assign cur_addr   = addr_w'(ph_cnt);
  assign prev_addr  = addr_w'(ph_cnt - 1'b1);
  assign cur_field  = INST_ADDR_W'(cur_addr);
  assign prev_field = INST_ADDR_W'(prev_addr);
  assign not_first  = (ph_cnt != '0);
  assign below_len  = (ph_cnt < LEN_C);
  assign below_col  = (ph_cnt < COL_C);

  // Timed states: the read strobe covers cycles 0..n-1 and its consumer
  // (kload/execute/pmem_wr/norm) follows one cycle later, cycles 1..n.
  always_comb begin
    inst_d = '0;
    case (state_q)
      ST_QWR: if (in_valid) begin
        inst_d[INST_QMEM_WR] = 1'b1;
        inst_d[INST_QK_LSB +: INST_ADDR_W] = cur_field;
      end
      ST_KWR: if (in_valid) begin
        inst_d[INST_KMEM_WR] = 1'b1;
        inst_d[INST_QK_LSB +: INST_ADDR_W] = cur_field;
      end
      ST_KLOAD: begin
        if (below_col) begin
          inst_d[INST_KMEM_RD] = 1'b1;
          inst_d[INST_QK_LSB +: INST_ADDR_W] = cur_field;
        end
        inst_d[INST_KLOAD] = not_first;
      end
      ST_EXEC: begin
        if (below_len) begin
          inst_d[INST_QMEM_RD] = 1'b1;
          inst_d[INST_QK_LSB +: INST_ADDR_W] = cur_field;
        end
        inst_d[INST_EXEC] = not_first;
      end
      ST_PWR: begin
        inst_d[INST_OFIFO_RD] = below_len;
        if (not_first) begin
          inst_d[INST_PMEM_WR] = 1'b1;
          inst_d[INST_PSUM_LSB +: INST_ADDR_W] = prev_field;
        end
      end
      ST_NRD: begin
        if (below_len) begin
          inst_d[INST_PMEM_RD] = 1'b1;
          inst_d[INST_PSUM_LSB +: INST_ADDR_W] = cur_field;
        end
        inst_d[INST_NORM_VALID] = not_first;
      end
      ST_NWB: begin
        inst_d[INST_SFP_RD] = below_len;
        if (not_first) begin
          inst_d[INST_NORM_START] = 1'b1;
          inst_d[INST_PMEM_WR]    = 1'b1;
          inst_d[INST_PSUM_LSB +: INST_ADDR_W] = prev_field;
        end
      end
      default: ;
    endcase

    if (abort) begin
      inst_d = '0;
    end
  end

  // Status outputs are registered from the next state so they line up with
  // the state the sequencer is actually in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wd_q    <= '0;
      err_q   <= 1'b0;
      inst_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      inst_q  <= inst_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      ready_q <= (state_d == ST_QWR) || (state_d == ST_KWR);
    end
  end

  assign inst     = inst_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign in_ready = ready_q;
  assign err      = err_q;

endmodule
